// File: rtl/uart_sniff_pkg.sv
// Shared types for the UART console sniffer: FSM state encoding and byte width.
package uart_sniff_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } state_t;

endpackage

// File: rtl/sniff_fifo.sv
// First-word fall-through byte FIFO with occupancy count and sticky overflow flag.
module sniff_fifo
    import uart_sniff_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BYTE_W-1:0] push_data,
    input  logic              pop_req,
    output logic [BYTE_W-1:0] rd_data,
    output logic              valid,
    output logic [CNT_W-1:0]  cnt,
    output logic              overflow
);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [BYTE_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              full, empty, pop, wr;

    always_comb begin
        full     = (cnt_q == CNT_W'(DEPTH));
        empty    = (cnt_q == '0);
        pop      = pop_req && !empty;
        // A push into a full FIFO still lands if the head leaves in the same cycle.
        wr       = push && (!full || pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q | (push && !wr);
        if (wr) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({wr, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
        end
    end

    assign rd_data  = empty ? '0 : mem_q[rd_ptr_q];
    assign valid    = !empty;
    assign cnt      = cnt_q;
    assign overflow = ovf_q;

endmodule

// File: rtl/uart_rx_sniffer.sv
// UART receiver tap on the console TX line, buffering decoded bytes in a FWFT FIFO.
// Define UART_SNIFF_PARITY_EN for 8E1 framing with a parity_err pulse output.
//
// state     | meaning
// IDLE      | line idle, waiting for a falling edge
// START     | timing to the start-bit centre, rejecting glitches
// DATA      | sampling 8 data bits LSB first at bit centres
// PARITY    | sampling the even-parity bit (parity build only)
// STOP      | sampling the stop bit, pushing the byte if valid
// WAIT_IDLE | bad stop bit seen; waiting for the line to return high
module uart_rx_sniffer
    import uart_sniff_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rxd,
    output logic [BYTE_W-1:0]           rx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt,
    output logic                        busy,
    output logic                        frame_err,
`ifdef UART_SNIFF_PARITY_EN
    output logic                        parity_err,
`endif
    output logic                        overflow
);

    localparam int             CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] TICK_V = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_V = CNT_W'(CLK_DIV / 2 - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [BYTE_W-1:0] shreg_q, shreg_d;
    logic              rxd_meta_q, rxd_s_q;
    logic              frame_err_q, frame_err_d;
    logic              tick, push;
`ifdef UART_SNIFF_PARITY_EN
    logic              par_bad_q, par_bad_d;
    logic              parity_err_q, parity_err_d;
`endif

    always_comb begin
        tick        = (cnt_q == TICK_V);
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        push        = 1'b0;
`ifdef UART_SNIFF_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: if (!rxd_s_q) state_d = START;
            START: begin
                if (cnt_q == HALF_V) begin
                    state_d   = rxd_s_q ? IDLE : DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_d[bit_idx_q] = rxd_s_q;
                    bit_idx_d          = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_SNIFF_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_SNIFF_PARITY_EN
            PARITY: begin
                if (tick) begin
                    par_bad_d    = (rxd_s_q != ^shreg_q);
                    parity_err_d = par_bad_d;
                    state_d      = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (rxd_s_q) begin
`ifdef UART_SNIFF_PARITY_EN
                        push = !par_bad_q;
`else
                        push = 1'b1;
`endif
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: if (rxd_s_q) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        // Restart the bit timer on every state entry and on each bit boundary.
        if (state_d != state_q || tick || state_q == IDLE) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shreg_q     <= '0;
            rxd_meta_q  <= 1'b1;
            rxd_s_q     <= 1'b1;
            frame_err_q <= 1'b0;
`ifdef UART_SNIFF_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shreg_q     <= shreg_d;
            rxd_meta_q  <= rxd;
            rxd_s_q     <= rxd_meta_q;
            frame_err_q <= frame_err_d;
`ifdef UART_SNIFF_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    sniff_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg_q),
        .pop_req   (rx_ready),
        .rd_data   (rx_data),
        .valid     (rx_valid),
        .cnt       (fifo_cnt),
        .overflow  (overflow)
    );

    assign busy      = (state_q != IDLE);
    assign frame_err = frame_err_q;
`ifdef UART_SNIFF_PARITY_EN
    assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/uart_rx_sniffer.md
Name: uart_rx_sniffer

Overview:
- Synthesizable UART receiver and byte buffer attached directly downstream of the SoC's uart0_tx pin (fpioa[1]).
- Consumes the serial stream the core emits and decodes it into bytes.
- Buffers the bytes in a small FIFO and presents them on a valid/ready stream.
- Used by the simulation bench to capture firmware console output, and on FPGA boards as a loopback/console tap.

Parameters:
- CLK_DIV, 868, clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- FIFO_DEPTH, 16, byte entries; must be a power of two, range 2..256.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- rxd  in  1  serial input, asynchronous to clk, idle high.
- rx_data  out  8  head-of-FIFO byte (first-word fall-through).
- rx_valid  out  1  FIFO not empty.
- rx_ready  in  1  consumer accepts the head byte.
- fifo_cnt  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- busy  out  1  FSM is not in IDLE.
- frame_err  out  1  one-cycle pulse on a bad stop bit.
- overflow  out  1  sticky; a byte was dropped because the FIFO was full.

Behaviour:
- Reset (rst high at a clk edge):
  - Every output goes to 0; rx_data reads 8'h00.
  - FSM goes to IDLE and the FIFO is emptied.
  - A frame in progress is abandoned; no partial byte is ever pushed.
- Input sync: rxd passes through 2 flops to give rxd_s, reset value 1. All decisions use rxd_s.
- Bit timer: counter 0..CLK_DIV-1, reloaded to 0 on each state entry. A "tick" occurs when the counter equals CLK_DIV-1.
- FSM states:
  - IDLE: on rxd_s==0, go to START.
  - START: when the counter reaches CLK_DIV/2-1 (integer division), resample rxd_s. If 1 (glitch), return to IDLE. If 0, go to DATA with bit_idx=0 and restart the timer, so later samples land mid-bit.
  - DATA: on each tick, shift rxd_s into shreg[bit_idx] (LSB first) and increment bit_idx. After bit 7, go to STOP.
  - STOP: on tick, sample rxd_s. If 1, push shreg and go to IDLE. If 0, pulse frame_err, discard the byte and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rxd_s==1, then go to IDLE. This prevents a break condition from being read as a stream of 0x00 frames.
- Latency: rx_valid rises on the clk edge after the STOP sample cycle, about 2 cycles plus 9.5 bit times after the falling edge of the start bit.
- FIFO rules:
  - Pop happens when rx_valid && rx_ready; rx_data updates the next cycle.
  - Push while full and no pop: byte dropped, overflow set. overflow clears only on rst.
  - Push and pop in the same cycle while full: both take effect, no overflow, fifo_cnt unchanged.
  - Push while empty: rx_ready is ignored because rx_valid is low; the byte appears next cycle.
  - Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally. Full/empty come from fifo_cnt.
- Back-to-back frames: a new start bit may be detected in the cycle after the STOP→IDLE transition; no extra idle bit is required.

Optional Feature:
- UART_SNIFF_PARITY_EN.
  - Defined: adds a PARITY state between DATA and STOP that samples one even-parity bit on tick. It also adds output parity_err (1 bit), which pulses for one cycle when the parity is wrong; the byte is discarded and the FSM still goes through STOP normally.
  - Undefined: 8N1 framing only, no parity_err port, and the PARITY state does not exist.

Decomposition:
- Package uart_sniff_pkg:
  - enum state_t {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE}, encoded in 3 bits.
  - localparam BYTE_W=8.
- Sub-module sniff_fifo (synchronous FWFT FIFO, parameter DEPTH): holds the pointers, the count and the overflow logic. Serial decode stays in the top.

Test Plan (CLK_DIV=8, FIFO_DEPTH=4):
- Send 0x55 then 0xA3, 8N1 -> rx_valid with rx_data=0x55; pop -> 0xA3; frame_err=0, fifo_cnt back to 0.
- Start pulse 2 cycles low, then high -> FSM returns to IDLE, no push, busy drops within 4 cycles.
- Frame 0x3C with stop bit 0 held low for 30 cycles -> frame_err pulses once, fifo_cnt=0, no further frames until rxd is high, then 0x7E decodes correctly.
- Hold rx_ready=0, send 5 bytes 0x01..0x05 -> fifo_cnt=4, overflow=1; pops yield 0x01..0x04.
- FIFO full, rx_ready=1 exactly in the cycle 0x09 is pushed -> no overflow, cnt stays 4, order preserved.
- Assert rst mid-DATA of 0xFF -> all outputs 0, next frame 0x42 decodes clean. With UART_SNIFF_PARITY_EN, 0x07 with parity bit 0 -> parity_err pulse, no push.
